// File: rtl/dt_pkg.sv
// Shared definitions for the vout write scheduler: command codes, state encoding, FIFO default.
package dt_pkg;

   localparam int unsigned DEFAULT_FIFO_DEPTH = 2048;

   localparam logic [3:0] CMD_START = 4'h1;
   localparam logic [3:0] CMD_DATA  = 4'h2;
   localparam logic [3:0] CMD_STOP  = 4'h3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_DISCARD = 2'd3
   } state_e;

endpackage

// File: rtl/vout_write_sched_if.sv
// RX byte stream plus vout FIFO write port; slave is the scheduler, master is the RX/FIFO side.
interface vout_write_sched_if #(
   parameter int unsigned UW_W = $clog2(dt_pkg::DEFAULT_FIFO_DEPTH)
);
   logic [7:0]      rx_data;
   logic            rx_valid;
   logic            rx_last;
   logic            rx_user;
   logic            rx_ready;
   logic [3:0]      vout_fifow_data;
   logic            vout_fifow_request;
   logic [UW_W-1:0] vout_fifow_used_words;

   modport master (
      output rx_data, rx_valid, rx_last, rx_user,
      input  rx_ready,
      input  vout_fifow_data, vout_fifow_request,
      output vout_fifow_used_words
   );

   modport slave (
      input  rx_data, rx_valid, rx_last, rx_user,
      output rx_ready,
      output vout_fifow_data, vout_fifow_request,
      input  vout_fifow_used_words
   );
endinterface

// File: rtl/fifo_watermark.sv
// Registered hysteresis comparator: throttle sets at/above HIGH_WATER, clears at/below LOW_WATER.
module fifo_watermark #(
   parameter int unsigned UW_W       = 11,
   parameter int unsigned HIGH_WATER = 1984,
   parameter int unsigned LOW_WATER  = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [UW_W-1:0] used_words,
   output logic            throttle
);
   logic throttle_d, throttle_q;

   always_comb begin
      throttle_d = throttle_q;
      if (used_words >= UW_W'(HIGH_WATER)) begin
         throttle_d = 1'b1;
      end else if (used_words <= UW_W'(LOW_WATER)) begin
         throttle_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         throttle_q <= 1'b0;
      end else begin
         throttle_q <= throttle_d;
      end
   end

   assign throttle = throttle_q;
endmodule

// File: rtl/vout_write_sched.sv
// Owns the vout FIFO write port: decodes RX command nibbles, frames writes with START/STOP,
// throttles RX on FIFO fill level and drops errored packets.
module vout_write_sched
   import dt_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int unsigned HIGH_WATER = 1984,
   parameter int unsigned LOW_WATER  = 1024,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   vout_write_sched_if.slave    bus,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     nibble_count,
   output logic [CNT_W-1:0]     frame_err_count,
   output logic                 overflow
);
   localparam int unsigned UW_W = $clog2(FIFO_DEPTH);
   localparam logic [UW_W-1:0] FULL_LEVEL = UW_W'(FIFO_DEPTH - 1);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] nib_d, nib_q;
   logic [CNT_W-1:0] err_d, err_q;
   logic             ovf_d, ovf_q;
   logic             req_d, req_q;
   logic [3:0]       data_d, data_q;
   logic             ready_d, ready_q;
   logic             throttle;
   logic             accept;
   logic [3:0]       cmd;

   fifo_watermark #(
      .UW_W       (UW_W),
      .HIGH_WATER (HIGH_WATER),
      .LOW_WATER  (LOW_WATER)
   ) u_watermark (
      .clk        (clk),
      .rst        (rst),
      .used_words (bus.vout_fifow_used_words),
      .throttle   (throttle)
   );

   assign accept = bus.rx_valid && ready_q;
   assign cmd    = bus.rx_data[7:4];

   always_comb begin
      state_d = state_q;
      nib_d   = nib_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      req_d   = 1'b0;
      data_d  = data_q;
      if (accept && bus.rx_user) begin
         if (err_q != '1) begin
            err_d = err_q + 1'b1;
         end
         state_d = bus.rx_last ? ST_IDLE : ST_DISCARD;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept && cmd == CMD_START) begin
                  state_d = ST_STREAM;
                  nib_d   = '0;
               end
            end
            ST_STREAM: begin
               // START/STOP outrank a pending throttle; pause is re-evaluated next cycle.
               if (accept && cmd == CMD_START) begin
                  nib_d = '0;
               end else if (accept && cmd == CMD_STOP) begin
                  state_d = ST_IDLE;
               end else begin
                  if (accept && cmd == CMD_DATA) begin
                     if (bus.vout_fifow_used_words == FULL_LEVEL) begin
                        ovf_d = 1'b1;
                     end else begin
                        req_d  = 1'b1;
                        data_d = bus.rx_data[3:0];
                        nib_d  = nib_q + 1'b1;
                     end
                  end
                  if (throttle) begin
                     state_d = ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (!throttle) begin
                  state_d = ST_STREAM;
               end
            end
            ST_DISCARD: begin
               if (accept && bus.rx_last) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      ready_d = (state_d != ST_PAUSE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         nib_q   <= '0;
         err_q   <= '0;
         ovf_q   <= 1'b0;
         req_q   <= 1'b0;
         data_q  <= 4'h0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         nib_q   <= nib_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         req_q   <= req_d;
         data_q  <= data_d;
         ready_q <= ready_d;
      end
   end

   assign bus.rx_ready           = ready_q;
   assign bus.vout_fifow_request = req_q;
   assign bus.vout_fifow_data    = data_q;
   assign state                  = state_q;
   assign nibble_count           = nib_q;
   assign frame_err_count        = err_q;
   assign overflow               = ovf_q;
endmodule

// File: tb/tb_vout_write_sched.sv
// Self-checking bench for vout_write_sched: directed scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_vout_write_sched;
   import dt_pkg::*;

   localparam int M_IDLE    = 0;
   localparam int M_STREAM  = 1;
   localparam int M_DISCARD = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  state;
   logic [15:0] nibble_count;
   logic [15:0] frame_err_count;
   logic        overflow;

   int n_vec = 0;
   int n_err = 0;
   int act_writes = 0;
   int exp_writes = 0;

   int m_mode = M_IDLE;
   int m_nib  = 0;
   int m_err  = 0;
   bit m_ovf  = 1'b0;

   vout_write_sched_if #(.UW_W(11)) vif ();

   vout_write_sched #(
      .FIFO_DEPTH (2048),
      .HIGH_WATER (1984),
      .LOW_WATER  (1024),
      .CNT_W      (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (vif),
      .state           (state),
      .nibble_count    (nibble_count),
      .frame_err_count (frame_err_count),
      .overflow        (overflow)
   );

   always #4 clk = ~clk;

   always @(negedge clk) begin
      if (vif.vout_fifow_request === 1'b1) act_writes++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Packet-level reference: what one accepted byte should do.
   task automatic model_byte(input logic [7:0] d, input bit last, input bit user, input int used,
                             output bit wr, output logic [3:0] wd);
      logic [3:0] c;
      c  = d[7:4];
      wr = 1'b0;
      wd = d[3:0];
      if (user) begin
         if (m_err < 65535) m_err++;
         m_mode = last ? M_IDLE : M_DISCARD;
      end else if (m_mode == M_IDLE) begin
         if (c == 4'h1) begin
            m_mode = M_STREAM;
            m_nib  = 0;
         end
      end else if (m_mode == M_STREAM) begin
         if (c == 4'h1) begin
            m_nib = 0;
         end else if (c == 4'h3) begin
            m_mode = M_IDLE;
         end else if (c == 4'h2) begin
            if (used == 2047) begin
               m_ovf = 1'b1;
            end else begin
               wr    = 1'b1;
               m_nib = (m_nib + 1) % 65536;
               exp_writes++;
            end
         end
      end else if (last) begin
         m_mode = M_IDLE;
      end
   endtask

   task automatic send(input logic [7:0] d, input bit last, input bit user);
      bit         wr;
      logic [3:0] wd;
      int         w;
      @(negedge clk);
      vif.rx_data  = d;
      vif.rx_valid = 1'b1;
      vif.rx_last  = last;
      vif.rx_user  = user;
      w = 0;
      while (vif.rx_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      n_vec++;
      if (w >= 100) begin
         n_err++;
         $display("FAIL send_ready_timeout: rx_ready=%b, required 1 within 100 cycles", vif.rx_ready);
         vif.rx_valid = 1'b0;
         return;
      end
      model_byte(d, last, user, int'(vif.vout_fifow_used_words), wr, wd);
      @(posedge clk);
      #1;
      vif.rx_valid = 1'b0;
      vif.rx_last  = 1'b0;
      vif.rx_user  = 1'b0;
      n_vec++;
      if (vif.vout_fifow_request !== wr) begin
         n_err++;
         $display("FAIL write_request byte=%h: got %b, expected %b", d, vif.vout_fifow_request, wr);
      end
      if (wr) begin
         n_vec++;
         if (vif.vout_fifow_data !== wd) begin
            n_err++;
            $display("FAIL write_data byte=%h: got %h, expected %h", d, vif.vout_fifow_data, wd);
         end
      end
   endtask

   task automatic test_reset();
      vif.rx_data = 8'h00; vif.rx_valid = 1'b0; vif.rx_last = 1'b0; vif.rx_user = 1'b0;
      vif.vout_fifow_used_words = 11'd0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec += 7;
      if (vif.rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_rx_ready: got %b, expected 0", vif.rx_ready); end
      if (vif.vout_fifow_request !== 1'b0) begin n_err++; $display("FAIL reset_request: got %b, expected 0", vif.vout_fifow_request); end
      if (vif.vout_fifow_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h, expected 0", vif.vout_fifow_data); end
      if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d, expected 0", state); end
      if (nibble_count !== 16'd0) begin n_err++; $display("FAIL reset_nibble_count: got %0d, expected 0", nibble_count); end
      if (frame_err_count !== 16'd0) begin n_err++; $display("FAIL reset_err_count: got %0d, expected 0", frame_err_count); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
      rst = 1'b1;
      #1;
      n_vec++;
      if (vif.rx_ready !== 1'b0) begin n_err++; $display("FAIL release_ready_early: got %b, expected 0", vif.rx_ready); end
      @(posedge clk);
      #1;
      n_vec++;
      if (vif.rx_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b, expected 1", vif.rx_ready); end
   endtask

   task automatic test_idle_data();
      int w0;
      w0 = act_writes;
      send(8'h27, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_vec += 3;
      if (act_writes != w0) begin n_err++; $display("FAIL idle_data_writes: got %0d, expected 0", act_writes - w0); end
      if (nibble_count !== 16'(m_nib)) begin n_err++; $display("FAIL idle_nibble_count: got %0d, expected %0d", nibble_count, m_nib); end
      if (vif.rx_ready !== 1'b1) begin n_err++; $display("FAIL idle_rx_ready: got %b, expected 1", vif.rx_ready); end
   endtask

   task automatic test_basic_stream();
      int w0;
      w0 = act_writes;
      send(8'h10, 1'b0, 1'b0);
      send(8'h2A, 1'b0, 1'b0);
      send(8'h25, 1'b0, 1'b0);
      send(8'h30, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      n_vec += 3;
      if (act_writes - w0 != 2) begin n_err++; $display("FAIL basic_writes: got %0d, expected 2", act_writes - w0); end
      if (nibble_count !== 16'd2) begin n_err++; $display("FAIL basic_nibble_count: got %0d, expected 2", nibble_count); end
      if (state !== 2'(M_IDLE)) begin n_err++; $display("FAIL basic_state: got %0d, expected 0", state); end
   endtask

   task automatic test_throttle();
      int w0;
      send(8'h10, 1'b0, 1'b0);
      w0 = act_writes;
      @(negedge clk);
      vif.vout_fifow_used_words = 11'd1984;
      repeat (2) @(posedge clk);
      #1;
      n_vec += 2;
      if (vif.rx_ready !== 1'b0) begin n_err++; $display("FAIL throttle_ready: got %b, expected 0", vif.rx_ready); end
      if (state !== ST_PAUSE) begin n_err++; $display("FAIL throttle_state: got %0d, expected 2", state); end
      @(negedge clk);
      vif.vout_fifow_used_words = 11'd1500;
      vif.rx_data  = 8'h23;
      vif.rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_vec += 2;
         if (vif.rx_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready cycle %0d: got %b, expected 0", i, vif.rx_ready); end
         if (vif.vout_fifow_request !== 1'b0) begin n_err++; $display("FAIL hold_request cycle %0d: got %b, expected 0", i, vif.vout_fifow_request); end
      end
      @(negedge clk);
      vif.rx_valid = 1'b0;
      vif.vout_fifow_used_words = 11'd1024;
      repeat (2) @(posedge clk);
      #1;
      n_vec += 2;
      if (vif.rx_ready !== 1'b1) begin n_err++; $display("FAIL resume_ready: got %b, expected 1", vif.rx_ready); end
      if (state !== ST_STREAM) begin n_err++; $display("FAIL resume_state: got %0d, expected 1", state); end
      send(8'h26, 1'b0, 1'b0);
      send(8'h30, 1'b1, 1'b0);
      vif.vout_fifow_used_words = 11'd0;
      @(posedge clk);
      #1;
      n_vec++;
      if (act_writes - w0 != 1) begin n_err++; $display("FAIL throttle_writes: got %0d, expected 1", act_writes - w0); end
   endtask

   task automatic test_error_discard();
      int w0;
      w0 = act_writes;
      send(8'h10, 1'b0, 1'b0);
      send(8'h29, 1'b0, 1'b1);
      send(8'h21, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      send(8'h23, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      n_vec += 3;
      if (act_writes != w0) begin n_err++; $display("FAIL discard_writes: got %0d, expected 0", act_writes - w0); end
      if (frame_err_count !== 16'(m_err)) begin n_err++; $display("FAIL discard_err_count: got %0d, expected %0d", frame_err_count, m_err); end
      if (state !== 2'(M_IDLE)) begin n_err++; $display("FAIL discard_state: got %0d, expected 0", state); end
   endtask

   task automatic test_overflow();
      int w0;
      send(8'h10, 1'b0, 1'b0);
      w0 = act_writes;
      vif.vout_fifow_used_words = 11'd2047;
      send(8'h2F, 1'b0, 1'b0);
      vif.vout_fifow_used_words = 11'd100;
      n_vec++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b, expected 1", overflow); end
      send(8'h21, 1'b0, 1'b0);
      send(8'h30, 1'b1, 1'b0);
      send(8'h10, 1'b0, 1'b0);
      send(8'h24, 1'b0, 1'b0);
      send(8'h30, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_vec += 2;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b, expected 1", overflow); end
      if (act_writes - w0 != 2) begin n_err++; $display("FAIL overflow_writes: got %0d, expected 2", act_writes - w0); end
   endtask

   task automatic test_random();
      logic [7:0] pkt[$];
      int         n;
      int         errpos;
      int         w0;
      int         e0;
      w0 = act_writes;
      e0 = exp_writes;
      for (int p = 0; p < 30; p++) begin
         pkt.delete();
         if ($urandom_range(0, 5) != 0) pkt.push_back({4'h1, 4'($urandom)});
         n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) < 7) pkt.push_back({4'h2, 4'($urandom)});
            else pkt.push_back(8'($urandom));
         end
         pkt.push_back({4'h3, 4'($urandom)});
         errpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, pkt.size() - 1)) : -1;
         foreach (pkt[i]) begin
            vif.vout_fifow_used_words = 11'($urandom_range(0, 900));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(pkt[i], i == pkt.size() - 1, i == errpos);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      n_vec += 5;
      if (act_writes - w0 != exp_writes - e0) begin n_err++; $display("FAIL random_writes: got %0d, expected %0d", act_writes - w0, exp_writes - e0); end
      if (nibble_count !== 16'(m_nib)) begin n_err++; $display("FAIL random_nibble_count: got %0d, expected %0d", nibble_count, m_nib); end
      if (frame_err_count !== 16'(m_err)) begin n_err++; $display("FAIL random_err_count: got %0d, expected %0d", frame_err_count, m_err); end
      if (overflow !== m_ovf) begin n_err++; $display("FAIL random_overflow: got %b, expected %b", overflow, m_ovf); end
      if (state !== 2'(m_mode)) begin n_err++; $display("FAIL random_state: got %0d, expected %0d", state, m_mode); end
   endtask

   task automatic test_reset_midstream();
      int w0;
      vif.vout_fifow_used_words = 11'd10;
      send(8'h10, 1'b0, 1'b0);
      send(8'h2B, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      m_mode = M_IDLE; m_nib = 0; m_err = 0; m_ovf = 1'b0;
      n_vec += 6;
      if (vif.vout_fifow_request !== 1'b0) begin n_err++; $display("FAIL midreset_request: got %b, expected 0", vif.vout_fifow_request); end
      if (state !== 2'd0) begin n_err++; $display("FAIL midreset_state: got %0d, expected 0", state); end
      if (nibble_count !== 16'd0) begin n_err++; $display("FAIL midreset_nibble_count: got %0d, expected 0", nibble_count); end
      if (frame_err_count !== 16'd0) begin n_err++; $display("FAIL midreset_err_count: got %0d, expected 0", frame_err_count); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL midreset_overflow: got %b, expected 0", overflow); end
      if (vif.rx_ready !== 1'b0) begin n_err++; $display("FAIL midreset_ready: got %b, expected 0", vif.rx_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if (vif.rx_ready !== 1'b0) begin n_err++; $display("FAIL midrelease_ready_early: got %b, expected 0", vif.rx_ready); end
      @(posedge clk);
      #1;
      n_vec++;
      if (vif.rx_ready !== 1'b1) begin n_err++; $display("FAIL midrelease_ready: got %b, expected 1", vif.rx_ready); end
      w0 = act_writes;
      send(8'h2C, 1'b0, 1'b0);
      send(8'h30, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      n_vec += 3;
      if (act_writes != w0) begin n_err++; $display("FAIL post_reset_writes: got %0d, expected 0", act_writes - w0); end
      if (nibble_count !== 16'(m_nib)) begin n_err++; $display("FAIL post_reset_nibble_count: got %0d, expected %0d", nibble_count, m_nib); end
      if (state !== 2'(m_mode)) begin n_err++; $display("FAIL post_reset_state: got %0d, expected %0d", state, m_mode); end
   endtask

   initial begin
      test_reset();
      test_idle_data();
      test_basic_stream();
      test_throttle();
      test_error_discard();
      test_overflow();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
